// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer enabled by defining PIPE_STAGE_REG_SKID_EN.
module pipe_stage_reg #(
    parameter int unsigned           WIDTH  = 64,
    parameter logic [WIDTH-1:0]      BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_main;
    logic             r_main_valid;
    logic             w_accept;
    logic             w_xfer;

    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = r_main_valid & out_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;

`ifdef PIPE_STAGE_REG_SKID_EN

    logic [WIDTH-1:0] r_skid;
    logic             r_skid_valid;

    // Upstream ready comes only from the skid flop, breaking the out_ready path.
    assign in_ready = ~r_skid_valid;
    assign count    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    // NOTE: payload registers are reset too, because out_data must read as
    // BUBBLE whenever the stage is empty, including straight after reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main       <= BUBBLE;
            r_main_valid <= 1'b0;
            r_skid       <= BUBBLE;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid       <= BUBBLE;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= in_data;
            end else begin
                r_main       <= BUBBLE;
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Downstream stalled: park the in-flight beat in the skid entry.
            r_skid       <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

`else

    assign in_ready = out_ready | ~r_main_valid;
    assign count    = {1'b0, r_main_valid};

    // NOTE: payload registers are reset too, because out_data must read as
    // BUBBLE whenever the stage is empty, including straight after reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main       <= BUBBLE;
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= in_data;
            r_main_valid <= 1'b1;
        end else if (w_xfer) begin
            r_main       <= BUBBLE;
            r_main_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expectations follow the
// build mode selected by PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

    localparam logic [95:0] BUB96 = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  count;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [95:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [95:0] b_out_data;
    logic [1:0]  b_count;

    int n_cmp;
    int n_err;

    pipe_stage_reg dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    pipe_stage_reg #(.WIDTH(96), .BUBBLE(BUB96)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .flush    (b_flush),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .count    (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".out_valid"}, 96'(out_valid), 96'd0);
        check({tag, ".out_data"},  96'(out_data),  96'd0);
        check({tag, ".count"},     96'(count),     96'd0);
        check({tag, ".in_ready"},  96'(in_ready),  96'd1);
    endtask

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Power-up reset
        tick(); tick();
        reset = 1'b0;
        check_empty("reset");
        check("w96.reset.data",  b_out_data,          BUB96);
        check("w96.reset.valid", 96'(b_out_valid),    96'd0);

        // Streaming with downstream always ready
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h11;
        tick();
        check("stream.d11", 96'(out_data), 96'h11);
        check("stream.v11", 96'(out_valid), 96'd1);
        check("stream.c11", 96'(count), 96'd1);
        in_data = 64'h22;
        tick();
        check("stream.d22", 96'(out_data), 96'h22);
        check("stream.c22", 96'(count), 96'd1);
        in_data = 64'h33;
        tick();
        check("stream.d33", 96'(out_data), 96'h33);
        check("stream.c33", 96'(count), 96'd1);
        in_valid = 1'b0;
        tick();
        check_empty("stream.drain");

        // Downstream stall for three edges while offering 0xA then 0xB
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
        tick();
        check("stall1.data", 96'(out_data), 96'hA);
        check("stall1.in_ready", 96'(in_ready), SKID ? 96'd1 : 96'd0);
        in_data = 64'hB;
        tick();
        check("stall2.count", 96'(count), SKID ? 96'd2 : 96'd1);
        check("stall2.in_ready", 96'(in_ready), 96'd0);
        tick();
        check("stall3.data", 96'(out_data), 96'hA);
        check("stall3.count", 96'(count), SKID ? 96'd2 : 96'd1);
        check("stall3.in_ready", 96'(in_ready), 96'd0);
        // Release: base still has 0xB waiting upstream, skid already holds it
        out_ready = 1'b1;
        in_valid = SKID ? 1'b0 : 1'b1;
        #1;
        check("release.in_ready", 96'(in_ready), SKID ? 96'd0 : 96'd1);
        tick();
        check("release.dataB", 96'(out_data), 96'hB);
        check("release.validB", 96'(out_valid), 96'd1);
        check("release.countB", 96'(count), 96'd1);
        check("release.in_ready", 96'(in_ready), 96'd1);
        in_valid = 1'b0;
        tick();
        check_empty("release.drain");

        // Flush with the stage full and a beat on offer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hC1;
        tick();
        in_data = 64'hC2;
        tick();
        check("preflush.count", 96'(count), SKID ? 96'd2 : 96'd1);
        flush = 1'b1; in_data = 64'hC3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_empty("flush");
        out_ready = 1'b1;
        tick();
        check("flush.after.valid", 96'(out_valid), 96'd0);
        check("flush.after.data", 96'(out_data), 96'd0);

        // Back-to-back accept and transfer: no bubbles, count stays 1
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 64'h100 + 64'(i);
            tick();
            check("b2b.data", 96'(out_data), 96'h100 + 96'(i));
            check("b2b.count", 96'(count), 96'd1);
        end
        in_valid = 1'b0;
        tick();
        check_empty("b2b.drain");

        // Reset in the middle of a stall with the stage full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD1;
        tick();
        in_data = 64'hD2;
        tick();
        check("prereset.count", 96'(count), SKID ? 96'd2 : 96'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check_empty("midreset");

        // Flush and reset together
        in_valid = 1'b1; in_data = 64'hE1;
        tick();
        check("prefr.data", 96'(out_data), 96'hE1);
        reset = 1'b1; flush = 1'b1; in_data = 64'hE2;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_empty("flush_reset");

        // Wide instance: payload passes, then drains back to its BUBBLE
        b_out_ready = 1'b1; b_in_valid = 1'b1;
        b_in_data = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
        tick();
        check("w96.data",  b_out_data, 96'h0123_4567_89AB_CDEF_0F1E_2D3C);
        check("w96.valid", 96'(b_out_valid), 96'd1);
        b_in_valid = 1'b0;
        tick();
        check("w96.drain.data",  b_out_data, BUB96);
        check("w96.drain.valid", 96'(b_out_valid), 96'd0);
        check("w96.drain.count", 96'(b_count), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
